// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer. It redirects on accepted taken predictions and recovers on mispredicts.
// It uses a FIFO of in-flight branch predictions that are resolved in order by execute.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pred_valid,
  input  logic        pred_take,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic [31:0] pc_out,
  output logic        flush_f1_f2,
  output logic        flush_f2_d,
  output logic        flush_d_e,
  output logic        q_full,
  output logic        err,
  output logic [15:0] mispred_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          err_flag;
  logic [15:0]   mp_cnt;

  logic          take_q [QDEPTH];
  logic [31:0]   rec_q  [QDEPTH];

  logic          q_empty;
  logic          full;
  logic          mispredict;
  logic          pop;
  logic          push;
  logic          take_acc;
  logic          proto_err;
  logic [31:0]   rec_pc;
  logic [31:0]   next_pc;

  assign q_empty    = (count == '0);
  assign full       = (count == CW'(QDEPTH));
  assign mispredict = res_valid & ~q_empty & (res_taken != take_q[rd_ptr]);
  assign pop        = res_valid & ~q_empty;
  assign push       = ~stall & pred_valid & ~mispredict & (~full | pop);
  assign take_acc   = ~stall & pred_valid & pred_take & ~mispredict;
  assign proto_err  = (~stall & pred_valid & full & ~pop) | (res_valid & q_empty);
  // A taken prediction recovers to the fall-through path; a not-taken one recovers to the target.
  assign rec_pc     = pred_take ? (pred_pc + 32'd4) : pred_target;

  always_comb begin
    next_pc = pc + 32'd4;
    if (mispredict)    next_pc = rec_pc_head();
    else if (take_acc) next_pc = pred_target;
    else if (stall)    next_pc = pc;
  end

  function automatic logic [31:0] rec_pc_head();
    return rec_q[rd_ptr];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err_flag <= 1'b0;
      mp_cnt   <= 16'h0000;
    end else begin
      pc       <= next_pc;
      err_flag <= err_flag | proto_err;
      if (mispredict) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (mp_cnt != 16'hFFFF) mp_cnt <= mp_cnt + 16'd1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      take_q[wr_ptr] <= pred_take;
      rec_q[wr_ptr]  <= rec_pc;
    end
  end

  assign pc_out      = pc;
  assign flush_f1_f2 = ~rst & (mispredict | take_acc);
  assign flush_f2_d  = ~rst & mispredict;
  assign flush_d_e   = ~rst & mispredict;
  assign q_full      = full;
  assign err         = err_flag;
  assign mispred_cnt = mp_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl. Each checked cycle queues its hand-computed expectation.
// A negedge monitor pops those expectations and compares them against the DUT outputs.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pred_valid;
  logic        pred_take;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] pc_out;
  logic        flush_f1_f2;
  logic        flush_f2_d;
  logic        flush_d_e;
  logic        q_full;
  logic        err;
  logic [15:0] mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [2:0]  flush;
    logic        full;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pred_valid(pred_valid), .pred_take(pred_take),
    .pred_pc(pred_pc), .pred_target(pred_target), .res_valid(res_valid), .res_taken(res_taken),
    .pc_out(pc_out), .flush_f1_f2(flush_f1_f2), .flush_f2_d(flush_f2_d), .flush_d_e(flush_d_e),
    .q_full(q_full), .err(err), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, expv);
    end
  endtask

  // Monitor: one queued expectation is consumed per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc_out", pc_out, e.pc);
      chk(e.name, "flush", {29'd0, flush_f1_f2, flush_f2_d, flush_d_e}, {29'd0, e.flush});
      chk(e.name, "q_full", {31'd0, q_full}, {31'd0, e.full});
      chk(e.name, "err", {31'd0, err}, {31'd0, e.err});
      chk(e.name, "mispred_cnt", {16'd0, mispred_cnt}, {16'd0, e.cnt});
    end
  end

  task automatic drive(input logic r, input logic s, input logic pv, input logic pt,
                       input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic rv, input logic rt);
    @(posedge clk);
    #1;
    rst = r; stall = s; pred_valid = pv; pred_take = pt;
    pred_pc = ppc; pred_target = ptgt; res_valid = rv; res_taken = rt;
  endtask

  task automatic expect_now(input string nm, input logic [31:0] pc, input logic [2:0] fl,
                            input logic full, input logic e, input logic [15:0] cnt);
    exp_t x;
    x.name = nm; x.pc = pc; x.flush = fl; x.full = full; x.err = e; x.cnt = cnt;
    exp_q.push_back(x);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; pred_valid = 1'b0; pred_take = 1'b0;
    pred_pc = '0; pred_target = '0; res_valid = 1'b0; res_taken = 1'b0;
    @(posedge clk);

    // Reset state; flushes must stay low even with resolve asserted during reset.
    drive(1, 0, 0, 0, 32'h0, 32'h0, 1, 1);            expect_now("rst_hold", 32'h0, 3'b000, 0, 0, 16'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("idle0", 32'h0, 3'b000, 0, 0, 16'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("idle1", 32'h4, 3'b000, 0, 0, 16'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("idle2", 32'h8, 3'b000, 0, 0, 16'd0);
    // Taken prediction redirects to the target; the recovery path is 0x14.
    drive(0, 0, 1, 1, 32'h10, 32'h80, 0, 0);          expect_now("pred_taken", 32'hC, 3'b100, 0, 0, 16'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 0);            expect_now("mispred1", 32'h80, 3'b111, 0, 0, 16'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("recover1", 32'h14, 3'b000, 0, 0, 16'd1);
    // Fill the queue with four not-taken branches.
    drive(0, 0, 1, 0, 32'h20, 32'h100, 0, 0);         expect_now("push_a", 32'h18, 3'b000, 0, 0, 16'd1);
    drive(0, 0, 1, 0, 32'h24, 32'h104, 0, 0);         expect_now("push_b", 32'h1C, 3'b000, 0, 0, 16'd1);
    drive(0, 0, 1, 0, 32'h28, 32'h108, 0, 0);         expect_now("push_c", 32'h20, 3'b000, 0, 0, 16'd1);
    drive(0, 0, 1, 0, 32'h2C, 32'h10C, 0, 0);         expect_now("push_d", 32'h24, 3'b000, 0, 0, 16'd1);
    // At full, a correct resolve plus a push is legal; a lone push is an error.
    drive(0, 0, 1, 0, 32'h30, 32'h110, 1, 0);         expect_now("push_pop_full", 32'h28, 3'b000, 1, 0, 16'd1);
    drive(0, 0, 1, 0, 32'h34, 32'h114, 0, 0);         expect_now("push_full", 32'h2C, 3'b000, 1, 0, 16'd1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("err_set", 32'h30, 3'b000, 1, 1, 16'd1);
    // A stall holds the PC, and a taken prediction under stall is ignored.
    drive(0, 1, 1, 1, 32'h40, 32'h200, 0, 0);         expect_now("stall0", 32'h34, 3'b000, 1, 1, 16'd1);
    drive(0, 1, 1, 1, 32'h40, 32'h200, 0, 0);         expect_now("stall1", 32'h34, 3'b000, 1, 1, 16'd1);
    drive(0, 1, 1, 1, 32'h40, 32'h200, 0, 0);         expect_now("stall2", 32'h34, 3'b000, 1, 1, 16'd1);
    drive(0, 1, 1, 1, 32'h40, 32'h200, 1, 1);         expect_now("stall_mispred", 32'h34, 3'b111, 1, 1, 16'd1);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("stall_recover", 32'h104, 3'b000, 0, 1, 16'd2);
    // A stalled prediction must not push; the following resolve sees an empty queue.
    drive(0, 1, 1, 0, 32'h50, 32'h300, 0, 0);         expect_now("stall_nopush", 32'h108, 3'b000, 0, 1, 16'd2);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 1);            expect_now("res_empty", 32'h108, 3'b000, 0, 1, 16'd2);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("post_empty", 32'h10C, 3'b000, 0, 1, 16'd2);

    // Drive the counter up to 0xFFFF (2 + 65533 more mispredicts), unchecked.
    for (int i = 0; i < 65533; i++) begin
      drive(0, 0, 1, 0, 32'h60, 32'h400, 0, 0);
      drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 1);
    end
    drive(0, 0, 1, 0, 32'h60, 32'h400, 0, 0);         expect_now("sat_reached", 32'h400, 3'b000, 0, 1, 16'hFFFF);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 1);            expect_now("sat_mispred", 32'h404, 3'b111, 0, 1, 16'hFFFF);
    drive(0, 0, 1, 0, 32'h70, 32'h500, 0, 0);         expect_now("sat_hold", 32'h400, 3'b000, 0, 1, 16'hFFFF);
    // Reset asserted during a would-be mispredict wins and clears all state.
    drive(1, 0, 0, 0, 32'h0, 32'h0, 1, 1);            expect_now("rst_mispred", 32'h404, 3'b000, 0, 1, 16'hFFFF);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 1, 1);            expect_now("after_rst", 32'h0, 3'b000, 0, 0, 16'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);            expect_now("after_rst_err", 32'h4, 3'b000, 0, 1, 16'd0);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 4, in-flight branch queue depth (power of two, >=2).
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold fetch PC; suppresses prediction acceptance.
REQ-006 pred_valid  in  1  F2 holds a branch; prediction inputs valid this cycle.
REQ-007 pred_take  in  1  predictor taken/not-taken for the F2 branch.
REQ-008 pred_pc  in  32  PC of the F2 branch.
REQ-009 pred_target  in  32  taken target of the F2 branch.
REQ-010 res_valid  in  1  execute stage resolves the oldest in-flight branch.
REQ-011 res_taken  in  1  actual branch outcome.
REQ-012 pc_out  out  32  current fetch PC (registered).
REQ-013 flush_f1_f2 / flush_f2_d / flush_d_e  out  1 each  pipeline-register flushes (combinational).
REQ-014 q_full  out  1  in-flight queue holds QDEPTH entries.
REQ-015 err  out  1  sticky protocol-error flag.
REQ-016 mispred_cnt  out  16  saturating count of mispredictions.

Function
REQ-017 Queue entry SHALL store {pred_take, recovery_pc}; recovery_pc = pred_pc+4 if pred_take=1, else pred_target.
REQ-018 Mispredict SHALL be res_valid & queue non-empty & (res_taken != head.pred_take).
REQ-019 Next-PC priority SHALL be: mispredict -> head.recovery_pc; else (!stall & pred_valid & pred_take) -> pred_target; else stall -> hold; else pc_out+4 (mod 2^32 wrap).
REQ-020 pc_out SHALL update one cycle after the deciding inputs; no other latency.
REQ-021 On mispredict, flush_f1_f2, flush_f2_d, flush_d_e SHALL all be 1 in the same cycle, regardless of stall.
REQ-022 On accepted taken prediction without mispredict, flush_f1_f2 SHALL be 1 that cycle; other flushes 0.
REQ-023 Push SHALL occur when !stall & pred_valid & !mispredict & (count<QDEPTH or pop-this-cycle).
REQ-024 Pop SHALL occur when res_valid & count>0; pop and push in the same cycle leave count unchanged, legal at full.
REQ-025 On mispredict the queue SHALL be cleared (count=0) next cycle; a same-cycle pred_valid SHALL be dropped.
REQ-026 pred_valid with stall=1 SHALL neither push nor redirect.
REQ-027 pred_valid while full with no pop, and res_valid while empty, SHALL be ignored and set err=1.
REQ-028 err SHALL remain 1 until reset.
REQ-029 mispred_cnt SHALL increment by 1 per mispredict, saturating at 16'hFFFF.
REQ-030 q_full SHALL equal (count==QDEPTH), registered-state derived.

Reset
REQ-031 On rst=1 at a clock edge: pc_out=RESET_PC, count=0, read/write pointers=0, err=0, mispred_cnt=0.
REQ-032 Reset SHALL override every other input, including a mid-cycle mispredict or push.
REQ-033 Flush outputs SHALL be 0 while rst=1.

Verification
REQ-034 Reset then 3 idle cycles -> pc_out = 0x0, 0x4, 0x8, 0xC; no flushes.
REQ-035 pred_valid=1, pred_take=1, pred_pc=0x10, pred_target=0x80 -> flush_f1_f2=1 that cycle, pc_out=0x80 next, queue head recovery=0x14.
REQ-036 Then res_valid=1, res_taken=0 -> all three flushes=1, pc_out=0x14 next, q empty, mispred_cnt=1.
REQ-037 4 not-taken pushes (q_full=1), then push+pop same cycle with correct prediction -> q_full stays 1, err=0; push alone -> dropped, err=1.
REQ-038 stall=1 with pred_valid=1 for 3 cycles -> pc_out held, no push; mispredict during stall -> redirect and flushes still occur.
REQ-039 Force mispred_cnt to 0xFFFF via 65535 mispredicts -> further mispredict leaves 0xFFFF; rst mid-mispredict -> pc_out=RESET_PC.
